// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259A-style interrupt scheduler.
// Priority ranks are 3-bit wrap-around offsets from the current lowest-priority level.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACK1,
        ACK2
    } sched_state_e;

    localparam logic [2:0] SPURIOUS_LVL = 3'd7;

    // Rank 0 is the highest priority: the level just above lp.
    function automatic logic [2:0] rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] lvl);
        return 8'd1 << lvl;
    endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// Combinational priority resolver: finds the highest-rank set bit of an
// 8-bit vector given the current lowest-priority level.
module pic_prio_resolver
    import pic_pkg::*;
(
    input  logic [7:0] req,
    input  logic [2:0] lp,
    output logic       found,
    output logic [2:0] lvl
);

    always_comb begin
        found = 1'b0;
        lvl   = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i] && (!found || (rank(3'(i), lp) < rank(lvl, lp)))) begin
                found = 1'b1;
                lvl   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/pic_irq_sched.sv
// Interrupt scheduler: IRR/ISR state, fully nested priority resolution with
// rotation, EOI handling and the two-pulse INTA acknowledge sequence.
module pic_irq_sched
    import pic_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ir,
    input  logic [7:0] imr,
    input  logic       ltim,
    input  logic       aeoi,
    input  logic       rot_aeoi,
    input  logic       inta,
    input  logic       eoi_stb,
    input  logic       eoi_sl,
    input  logic       eoi_rot,
    input  logic [2:0] eoi_lvl,
    input  logic       setpri_stb,
    output logic       int_req,
    output logic [2:0] vec_code,
    output logic       vec_valid,
    output logic [7:0] irr,
    output logic [7:0] isr,
    output logic [2:0] lp
);

    sched_state_e state, state_next;
    logic [7:0]   ir_q;
    logic         inta_q;
    logic [2:0]   cur;
    logic         spur;
    logic         inta_rise, inta_fall;
    logic         ack_first, ack_second;
    logic         cand_found, isr_found;
    logic [2:0]   cand_lvl, isr_lvl;
    logic         eoi_hit;
    logic [2:0]   eoi_tgt;
    logic [7:0]   irr_next, isr_next;
    logic [2:0]   lp_next;
    logic         int_req_next;

    assign inta_rise = inta & ~inta_q;
    assign inta_fall = ~inta & inta_q;

    pic_prio_resolver u_cand_res (
        .req   (irr & ~imr),
        .lp    (lp),
        .found (cand_found),
        .lvl   (cand_lvl)
    );

    pic_prio_resolver u_isr_res (
        .req   (isr),
        .lp    (lp),
        .found (isr_found),
        .lvl   (isr_lvl)
    );

    always_comb begin
        state_next = state;
        ack_first  = 1'b0;
        ack_second = 1'b0;
        case (state)
            IDLE: if (inta_rise) begin
                state_next = ACK1;
                ack_first  = 1'b1;
            end
            ACK1: if (inta_fall) state_next = ACK2;
            ACK2: if (inta_rise) begin
                state_next = IDLE;
                ack_second = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // EOI clears first, then the acknowledge sets; setpri always wins on lp.
    always_comb begin
        eoi_tgt  = eoi_sl ? eoi_lvl : isr_lvl;
        eoi_hit  = eoi_stb && (eoi_sl ? isr[eoi_lvl] : isr_found);
        isr_next = isr;
        lp_next  = lp;
        if (eoi_hit) begin
            isr_next = isr_next & ~onehot8(eoi_tgt);
            if (eoi_rot) lp_next = eoi_tgt;
        end
        if (ack_first && cand_found) isr_next = isr_next | onehot8(cand_lvl);
        if (ack_second && aeoi && !spur) begin
            isr_next = isr_next & ~onehot8(cur);
            if (rot_aeoi) lp_next = cur;
        end
        if (setpri_stb) lp_next = eoi_lvl;

        if (ltim) begin
            irr_next = ir;
        end else begin
            irr_next = irr | (ir & ~ir_q);
            if (ack_first && cand_found) irr_next = irr_next & ~onehot8(cand_lvl);
        end

        int_req_next = (state == IDLE) && !inta_rise && cand_found &&
                       (!isr_found || (rank(cand_lvl, lp) < rank(isr_lvl, lp)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ir_q      <= 8'd0;
            inta_q    <= 1'b0;
            irr       <= 8'd0;
            isr       <= 8'd0;
            lp        <= 3'd7;
            int_req   <= 1'b0;
            vec_code  <= 3'd0;
            vec_valid <= 1'b0;
            cur       <= 3'd0;
            spur      <= 1'b0;
        end else begin
            ir_q      <= ir;
            inta_q    <= inta;
            irr       <= irr_next;
            isr       <= isr_next;
            lp        <= lp_next;
            int_req   <= int_req_next;
            vec_valid <= ack_second;
            if (ack_first) begin
                cur  <= cand_found ? cand_lvl : SPURIOUS_LVL;
                spur <= !cand_found;
            end
            if (ack_second) vec_code <= cur;
        end
    end

endmodule

// File: tb/tb_pic_irq_sched.sv
// Directed self-checking bench for pic_irq_sched with hand-computed expectations.
module tb_pic_irq_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ir, imr;
    logic       ltim, aeoi, rot_aeoi, inta;
    logic       eoi_stb, eoi_sl, eoi_rot, setpri_stb;
    logic [2:0] eoi_lvl;
    logic       int_req, vec_valid;
    logic [2:0] vec_code, lp;
    logic [7:0] irr, isr;

    int checks = 0;
    int fails  = 0;

    pic_irq_sched dut (
        .clk        (clk),
        .reset      (reset),
        .ir         (ir),
        .imr        (imr),
        .ltim       (ltim),
        .aeoi       (aeoi),
        .rot_aeoi   (rot_aeoi),
        .inta       (inta),
        .eoi_stb    (eoi_stb),
        .eoi_sl     (eoi_sl),
        .eoi_rot    (eoi_rot),
        .eoi_lvl    (eoi_lvl),
        .setpri_stb (setpri_stb),
        .int_req    (int_req),
        .vec_code   (vec_code),
        .vec_valid  (vec_valid),
        .irr        (irr),
        .isr        (isr),
        .lp         (lp)
    );

    always #5 clk = ~clk;

    // Advance n clock edges, leaving time 1 unit past the last rising edge.
    task automatic applyStimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ir = 8'h00; imr = 8'h00; ltim = 1'b0; aeoi = 1'b0;
        rot_aeoi = 1'b0; inta = 1'b0; eoi_stb = 1'b0; eoi_sl = 1'b0;
        eoi_rot = 1'b0; eoi_lvl = 3'd0; setpri_stb = 1'b0;
        applyStimulus(2);
        reset = 1'b0;
        checkOutput("reset_int_req", 8'(int_req), 8'h0);
        checkOutput("reset_isr", isr, 8'h00);
        checkOutput("reset_irr", irr, 8'h00);
        checkOutput("reset_lp", 8'(lp), 8'h7);
        checkOutput("reset_vec_valid", 8'(vec_valid), 8'h0);

        // Basic edge request on IR3
        $display("[TB] basic edge request");
        ir = 8'h08;
        applyStimulus(1);
        checkOutput("basic_irr", irr, 8'h08);
        checkOutput("basic_int_early", 8'(int_req), 8'h0);
        applyStimulus(1);
        checkOutput("basic_int_req", 8'(int_req), 8'h1);
        ir = 8'h00; inta = 1'b1;
        applyStimulus(1);
        checkOutput("basic_ack1_isr", isr, 8'h08);
        checkOutput("basic_ack1_irr", irr, 8'h00);
        checkOutput("basic_ack1_int", 8'(int_req), 8'h0);
        inta = 1'b0;
        applyStimulus(1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("basic_vec_valid", 8'(vec_valid), 8'h1);
        checkOutput("basic_vec_code", 8'(vec_code), 8'h3);
        inta = 1'b0;
        applyStimulus(1);
        checkOutput("basic_vec_valid_drop", 8'(vec_valid), 8'h0);

        // Nesting: ISR3 blocks IR5 but not IR1
        $display("[TB] nesting");
        ir = 8'h20;
        applyStimulus(2);
        checkOutput("nest_irr5", irr, 8'h20);
        checkOutput("nest_ir5_blocked", 8'(int_req), 8'h0);
        ir = 8'h22;
        applyStimulus(2);
        checkOutput("nest_ir1_int", 8'(int_req), 8'h1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("nest_ack_isr", isr, 8'h0A);
        checkOutput("nest_ack_irr", irr, 8'h20);
        inta = 1'b0;
        applyStimulus(1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("nest_vec_code", 8'(vec_code), 8'h1);
        inta = 1'b0;
        applyStimulus(1);
        checkOutput("nest_int_after_ack", 8'(int_req), 8'h0);
        eoi_stb = 1'b1;
        applyStimulus(1);
        eoi_stb = 1'b0;
        checkOutput("nest_eoi_isr", isr, 8'h08);
        ir = 8'h00;
        doReset();

        // Rotation: lowest priority 4 makes IR5 highest
        $display("[TB] rotation");
        setpri_stb = 1'b1; eoi_lvl = 3'd4;
        applyStimulus(1);
        setpri_stb = 1'b0;
        checkOutput("rot_setpri_lp", 8'(lp), 8'h4);
        ir = 8'h21;
        applyStimulus(2);
        checkOutput("rot_int_req", 8'(int_req), 8'h1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("rot_ack_isr", isr, 8'h20);
        checkOutput("rot_ack_irr", irr, 8'h01);
        inta = 1'b0;
        applyStimulus(1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("rot_vec_code", 8'(vec_code), 8'h5);
        inta = 1'b0;
        applyStimulus(1);
        eoi_stb = 1'b1; eoi_rot = 1'b1;
        applyStimulus(1);
        eoi_stb = 1'b0; eoi_rot = 1'b0;
        checkOutput("rot_eoi_lp", 8'(lp), 8'h5);
        checkOutput("rot_eoi_isr", isr, 8'h00);
        ir = 8'h00;
        doReset();

        // AEOI with rotation on IR2
        $display("[TB] aeoi rotate");
        aeoi = 1'b1; rot_aeoi = 1'b1; ir = 8'h04;
        applyStimulus(2);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("aeoi_ack1_isr", isr, 8'h04);
        inta = 1'b0;
        applyStimulus(1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("aeoi_vec_valid", 8'(vec_valid), 8'h1);
        checkOutput("aeoi_vec_code", 8'(vec_code), 8'h2);
        checkOutput("aeoi_isr", isr, 8'h00);
        checkOutput("aeoi_lp", 8'(lp), 8'h2);
        inta = 1'b0; aeoi = 1'b0; rot_aeoi = 1'b0; ir = 8'h00;
        doReset();

        // Spurious acknowledge in level mode
        $display("[TB] spurious level mode");
        ltim = 1'b1; ir = 8'h40;
        applyStimulus(2);
        checkOutput("spur_int_req", 8'(int_req), 8'h1);
        ir = 8'h00;
        applyStimulus(1);
        checkOutput("spur_irr_lost", irr, 8'h00);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("spur_ack1_isr", isr, 8'h00);
        inta = 1'b0;
        applyStimulus(1);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("spur_vec_code", 8'(vec_code), 8'h7);
        checkOutput("spur_vec_valid", 8'(vec_valid), 8'h1);
        checkOutput("spur_isr", isr, 8'h00);
        inta = 1'b0; ltim = 1'b0;
        doReset();

        // Reset asserted while in ACK2
        $display("[TB] reset in ACK2");
        ir = 8'h10;
        applyStimulus(2);
        inta = 1'b1;
        applyStimulus(1);
        inta = 1'b0; ir = 8'h00;
        applyStimulus(1);
        checkOutput("rst2_pre_isr", isr, 8'h10);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("rst2_isr", isr, 8'h00);
        checkOutput("rst2_irr", irr, 8'h00);
        checkOutput("rst2_int_req", 8'(int_req), 8'h0);
        checkOutput("rst2_vec_valid", 8'(vec_valid), 8'h0);
        checkOutput("rst2_lp", 8'(lp), 8'h7);
        inta = 1'b1;
        applyStimulus(1);
        checkOutput("rst2_state_idle", 8'(vec_valid), 8'h0);
        inta = 1'b0;
        applyStimulus(1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
